// File: rtl/lut_pkg.sv
// Shared definitions for the reverse-search lookup table.
// Holds the default geometry of the table and the finder FSM state type.
package lut_pkg;

  localparam int LUT_DEPTH  = 32;
  localparam int LUT_KEY_W  = 8;
  localparam int LUT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } finder_state_t;

  // Number of bits needed to index DEPTH entries (at least one bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/lut_table.sv
// Entry storage for the lookup table: data array plus per-entry valid bits.
// Ports:
//   clk, rst_n       clock and synchronous active-low reset (clears data and valid bits)
//   wr_en/wr_key/wr_data  write port; keys >= DEPTH are dropped
//   rd_key/rd_data   forward read, combinational; 0 for out-of-range or unwritten keys
//   srch_idx         index being examined by the reverse search
//   srch_data/srch_valid  contents of that entry before any same-cycle write
module lut_table
  import lut_pkg::*;
#(
  parameter int DEPTH  = LUT_DEPTH,
  parameter int KEY_W  = LUT_KEY_W,
  parameter int DATA_W = LUT_DATA_W,
  parameter int IDX_W  = idx_width(LUT_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [KEY_W-1:0]  wr_key,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [KEY_W-1:0]  rd_key,
  output logic [DATA_W-1:0] rd_data,
  input  logic [IDX_W-1:0]  srch_idx,
  output logic [DATA_W-1:0] srch_data,
  output logic              srch_valid
);

  logic [DATA_W-1:0] entry_r [DEPTH];
  logic [DEPTH-1:0]  valid_r;

  logic              wr_in_range_s;
  logic              rd_in_range_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [IDX_W-1:0]  rd_idx_s;

  assign wr_in_range_s = (wr_key < KEY_W'(DEPTH));
  assign rd_in_range_s = (rd_key < KEY_W'(DEPTH));
  assign wr_idx_s      = wr_key[IDX_W-1:0];
  assign rd_idx_s      = rd_key[IDX_W-1:0];

  // Entry and valid-bit storage with the single write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= '0;
      end
      valid_r <= '0;
    end else if (wr_en && wr_in_range_s) begin
      entry_r[wr_idx_s] <= wr_data;
      valid_r[wr_idx_s] <= 1'b1;
    end
  end

  // Forward read: only a written, in-range entry returns its contents.
  always_comb begin
    rd_data = '0;
    if (rd_in_range_s && valid_r[rd_idx_s]) begin
      rd_data = entry_r[rd_idx_s];
    end else begin
      rd_data = '0;
    end
  end

  // Search read port; reads the registered contents so a write in the
  // same cycle is only seen from the next edge onward.
  always_comb begin
    srch_data  = entry_r[srch_idx];
    srch_valid = valid_r[srch_idx];
  end

endmodule

// File: rtl/lut_reverse_finder.sv
// Writable lookup table with a sequential reverse search.
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   wr_en/wr_key/wr_data table write port
//   rd_key/rd_data       combinational forward lookup
//   req_valid/req_ready/req_value  reverse query handshake (value to find)
//   rsp_valid/rsp_ready/rsp_hit/rsp_key  result handshake; rsp_key is the
//                        lowest matching key, 0 on a miss
// The search walks one entry per cycle from key 0 upward and stops at the
// first match, so the lowest matching key is always the one reported.
module lut_reverse_finder
  import lut_pkg::*;
#(
  parameter int DEPTH  = LUT_DEPTH,
  parameter int KEY_W  = LUT_KEY_W,
  parameter int DATA_W = LUT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [KEY_W-1:0]  wr_key,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [KEY_W-1:0]  rd_key,
  output logic [DATA_W-1:0] rd_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_value,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic [KEY_W-1:0]  rsp_key
);

  localparam int IDX_W = idx_width(DEPTH);

  finder_state_t     state_r, state_s;
  logic [IDX_W-1:0]  idx_r, idx_s;
  logic [DATA_W-1:0] value_r, value_s;
  logic              rsp_hit_r, rsp_hit_s;
  logic [KEY_W-1:0]  rsp_key_r, rsp_key_s;

  logic [DATA_W-1:0] srch_data_s;
  logic              srch_valid_s;
  logic              match_s;
  logic              last_idx_s;

  lut_table #(
    .DEPTH  (DEPTH),
    .KEY_W  (KEY_W),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_key     (wr_key),
    .wr_data    (wr_data),
    .rd_key     (rd_key),
    .rd_data    (rd_data),
    .srch_idx   (idx_r),
    .srch_data  (srch_data_s),
    .srch_valid (srch_valid_s)
  );

  // Unwritten entries never match, even when searching for 0.
  assign match_s    = srch_valid_s && (srch_data_s == value_r);
  assign last_idx_s = (idx_r == IDX_W'(DEPTH - 1));

  // FSM state, search index, latched query and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      idx_r     <= '0;
      value_r   <= '0;
      rsp_hit_r <= 1'b0;
      rsp_key_r <= '0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      value_r   <= value_s;
      rsp_hit_r <= rsp_hit_s;
      rsp_key_r <= rsp_key_s;
    end
  end

  // Next-state and next-register logic; everything holds unless updated.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    value_s   = value_r;
    rsp_hit_s = rsp_hit_r;
    rsp_key_s = rsp_key_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          value_s = req_value;
          idx_s   = '0;
          state_s = SEARCH;
        end else begin
          state_s = IDLE;
        end
      end
      SEARCH: begin
        if (match_s) begin
          rsp_hit_s = 1'b1;
          rsp_key_s = KEY_W'(idx_r);
          state_s   = DONE;
        end else if (last_idx_s) begin
          // Index stops at the last entry rather than wrapping.
          rsp_hit_s = 1'b0;
          rsp_key_s = '0;
          state_s   = DONE;
        end else begin
          idx_s   = idx_r + IDX_W'(1);
          state_s = SEARCH;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Handshake flags are decoded straight from the state register.
  assign req_ready = (state_r == IDLE);
  assign rsp_valid = (state_r == DONE);
  assign rsp_hit   = rsp_hit_r;
  assign rsp_key   = rsp_key_r;

endmodule

// File: tb/tb_lut_reverse_finder.sv
// Self-checking bench for lut_reverse_finder: directed scenarios followed by
// randomized writes and queries compared against a table model.
module tb_lut_reverse_finder;

  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_key;
  logic [7:0] wr_data;
  logic [7:0] rd_key;
  logic [7:0] rd_data;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_value;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_hit;
  logic [7:0] rsp_key;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference table: what each key holds and whether it was ever written.
  logic [7:0] mem  [DEPTH];
  bit         mval [DEPTH];

  lut_reverse_finder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_key    (wr_key),
    .wr_data   (wr_data),
    .rd_key    (rd_key),
    .rd_data   (rd_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_value (req_value),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_hit   (rsp_hit),
    .rsp_key   (rsp_key)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_find(input logic [7:0] v);
    for (int k = 0; k < DEPTH; k++) begin
      if (mval[k] && mem[k] == v) return k;
    end
    return -1;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < DEPTH; k++) begin
      mem[k]  = 8'd0;
      mval[k] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int key, input int data);
    wr_en   = 1'b1;
    wr_key  = 8'(key);
    wr_data = 8'(data);
    tick();
    wr_en = 1'b0;
    if (key < DEPTH) begin
      mem[key]  = 8'(data);
      mval[key] = 1'b1;
    end
  endtask

  task automatic check_read(input string tag, input int key);
    int exp;
    rd_key = 8'(key);
    #1;
    exp = (key < DEPTH && mval[key]) ? int'(mem[key]) : 0;
    chk(tag, rd_data, exp);
  endtask

  // Issue a query, measure edges from acceptance to rsp_valid, optionally
  // stall the response for `hold` cycles, then take it.
  task automatic do_query(input string tag, input logic [7:0] v, input int hold);
    int k, exp_key, exp_lat, cnt;
    logic exp_hit;
    k       = ref_find(v);
    exp_hit = (k >= 0);
    exp_key = exp_hit ? k : 0;
    exp_lat = exp_hit ? k + 1 : DEPTH;
    chk({tag, " req_ready_idle"}, req_ready, 1);
    req_valid = 1'b1;
    req_value = v;
    tick();
    req_valid = 1'b0;
    req_value = 8'($urandom);
    cnt = 0;
    while (!rsp_valid && cnt < 40) begin
      tick();
      cnt++;
    end
    chk({tag, " latency"}, cnt, exp_lat);
    chk({tag, " hit"}, rsp_hit, exp_hit);
    chk({tag, " key"}, rsp_key, exp_key);
    chk({tag, " req_ready_busy"}, req_ready, 0);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_value = 8'($urandom);
      tick();
      chk({tag, " hold_valid"}, rsp_valid, 1);
      chk({tag, " hold_hit"}, rsp_hit, exp_hit);
      chk({tag, " hold_key"}, rsp_key, exp_key);
      chk({tag, " hold_req_ready"}, req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, " rsp_dropped"}, rsp_valid, 0);
    chk({tag, " req_ready_back"}, req_ready, 1);
  endtask

  initial begin
    int k;
    rst_n     = 1'b0;
    wr_en     = 1'b0;
    wr_key    = 8'd0;
    wr_data   = 8'd0;
    rd_key    = 8'd0;
    req_valid = 1'b0;
    req_value = 8'd0;
    rsp_ready = 1'b0;
    model_clear();
    tick();
    tick();
    rst_n = 1'b1;

    // 1: reset state, unwritten entries, query for 0 misses.
    chk("reset req_ready", req_ready, 1);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_hit", rsp_hit, 0);
    chk("reset rsp_key", rsp_key, 0);
    check_read("reset rd5", 5);
    do_query("q_zero", 8'd0, 0);

    // 2: sparse writes, forward read, hit near the end.
    wr(16, 2);
    wr(24, 9);
    wr(30, 136);
    check_read("rd24", 24);
    check_read("rd16", 16);
    check_read("rd_oor200", 200);
    do_query("q136", 8'd136, 0);

    // 3: duplicate values, lowest key wins.
    wr(3, 8'h23);
    wr(20, 8'h23);
    do_query("q23_lowest", 8'h23, 0);

    // 4: stalled response stays stable and blocks new queries.
    do_query("q23_stall", 8'h23, 10);

    // 5: write lands on the entry under examination -> pre-write compare.
    k = ref_find(8'h5B);
    chk("q5b precondition", k, -1);
    req_valid = 1'b1;
    req_value = 8'h5B;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    wr(7, 8'h5B);
    begin
      int cnt = 8;
      while (!rsp_valid && cnt < 40) begin
        tick();
        cnt++;
      end
      chk("q5b_race latency", cnt, DEPTH);
    end
    chk("q5b_race hit", rsp_hit, 0);
    chk("q5b_race key", rsp_key, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    do_query("q5b_repeat", 8'h5B, 0);

    // 6: reset in the middle of a search.
    req_valid = 1'b1;
    req_value = 8'd9;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_clear();
    chk("midreset req_ready", req_ready, 1);
    chk("midreset rsp_valid", rsp_valid, 0);
    chk("midreset rsp_hit", rsp_hit, 0);
    chk("midreset rsp_key", rsp_key, 0);
    for (int i = 0; i < DEPTH; i++) check_read("midreset rd", i);
    wr(40, 8'h77);
    for (int i = 0; i < DEPTH; i++) check_read("oor_write rd", i);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("midreset no_rsp", rsp_valid, 0);
    end

    // Randomized writes and queries over a small value range to force hits.
    for (int it = 0; it < 30; it++) begin
      int nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        wr($urandom_range(0, 39), $urandom_range(0, 15));
      end
      check_read("rand rd", $urandom_range(0, 40));
      do_query("rand q", 8'($urandom_range(0, 15)), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
